// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
// Holds the run-state encoding, one-hot directions and default timing values.
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READY = 3'd2,
        PLAY  = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam int DEF_FRAME_DIV     = 833333;
    localparam int DEF_BASE_FRAMES   = 15;
    localparam int DEF_MIN_FRAMES    = 4;
    localparam int DEF_SPEEDUP_EVERY = 4;
    localparam int DEF_CLEAR_CYCLES  = 19200;

    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        logic [3:0] opp;
        case (dir)
            DIR_UP:    opp = DIR_DOWN;
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_DOWN:  opp = DIR_UP;
            DIR_RIGHT: opp = DIR_LEFT;
            default:   opp = 4'b0000;
        endcase
        return opp;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move pacing: frame divider, per-move frame counter and the single-cycle move pulse.
// With SNAKE_CTRL_SPEEDUP_EN defined, frames per move shrinks with level; otherwise it is fixed.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int FRAME_DIV   = DEF_FRAME_DIV,
    parameter int BASE_FRAMES = DEF_BASE_FRAMES,
    parameter int MIN_FRAMES  = DEF_MIN_FRAMES
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic       clear,
    input  logic [3:0] level,
    output logic       move_tick
);

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int MW = $clog2(BASE_FRAMES + 1);

    logic [FW-1:0] frame_cnt;
    logic [MW-1:0] move_cnt;
    logic [MW-1:0] frames_per_move;
    logic          frame_strobe;

`ifdef SNAKE_CTRL_SPEEDUP_EN
    always_comb begin
        if (int'(level) >= BASE_FRAMES - MIN_FRAMES)
            frames_per_move = MW'(MIN_FRAMES);
        else
            frames_per_move = MW'(BASE_FRAMES - int'(level));
    end
`else
    logic unused_level;
    assign unused_level    = ^level;
    assign frames_per_move = MW'(BASE_FRAMES);
`endif

    assign frame_strobe = run && (frame_cnt == FW'(FRAME_DIV - 1));
    // >= rather than == so a level-up that shrinks the target below the running count still fires
    assign move_tick    = frame_strobe && (move_cnt >= frames_per_move - MW'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt <= '0;
            move_cnt  <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
            move_cnt  <= '0;
        end else if (frame_strobe) begin
            frame_cnt <= '0;
            move_cnt  <= move_tick ? '0 : move_cnt + MW'(1);
        end else if (run) begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-level sequencer for the snake datapath: run state, datapath controls and direction commit.
// Optional speed-up build: define SNAKE_CTRL_SPEEDUP_EN to let level rise with foods eaten.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int FRAME_DIV     = DEF_FRAME_DIV,
    parameter int BASE_FRAMES   = DEF_BASE_FRAMES,
    parameter int MIN_FRAMES    = DEF_MIN_FRAMES,
    parameter int SPEEDUP_EVERY = DEF_SPEEDUP_EVERY,
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [3:0] dir_req,
    input  logic       good_collision,
    input  logic       bad_collision,
    output logic       game_reset,
    output logic       game_display,
    output logic       snake_start,
    output logic       move_tick,
    output logic [3:0] dir_out,
    output logic [3:0] level,
    output logic [7:0] eaten,
    output logic       game_over,
    output logic [2:0] state_out
);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    state_t        state, next_state;
    logic          start_q, pause_q;
    logic          start_edge, pause_edge;
    logic [CW-1:0] clear_cnt;
    logic          clear_done;
    logic [3:0]    pending;
    logic          dir_accept;
    logic          tick;
    logic          food;
    logic          game_reset_d, game_display_d, snake_start_d, game_over_d;

    assign start_edge = start_btn & ~start_q;
    assign pause_edge = pause_btn & ~pause_q;
    assign clear_done = (clear_cnt == CW'(CLEAR_CYCLES - 1));
    assign food       = (state == PLAY) && good_collision && !bad_collision;
    assign state_out  = state;

    // Reversal is judged against the committed direction so two quick turns cannot fold the snake back
    assign dir_accept = ((state == READY) || (state == PLAY)) && is_onehot4(dir_req)
                        && (dir_req != opposite_dir(dir_out));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            game_reset   <= 1'b1;
            game_display <= 1'b0;
            snake_start  <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= next_state;
            start_q      <= start_btn;
            pause_q      <= pause_btn;
            game_reset   <= game_reset_d;
            game_display <= game_display_d;
            snake_start  <= snake_start_d;
            game_over    <= game_over_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start_edge) next_state = CLEAR;
            CLEAR: if (clear_done) next_state = READY;
            READY: if (dir_accept || start_edge) next_state = PLAY;
            PLAY: begin
                if (bad_collision)   next_state = OVER;
                else if (pause_edge) next_state = PAUSE;
            end
            PAUSE: begin
                if (start_edge)      next_state = CLEAR;
                else if (pause_edge) next_state = PLAY;
            end
            OVER:  if (start_edge) next_state = CLEAR;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from next_state so the registered controls line up with the state they belong to
    always_comb begin
        game_reset_d   = 1'b0;
        game_display_d = 1'b0;
        snake_start_d  = 1'b0;
        game_over_d    = 1'b0;
        case (next_state)
            IDLE, CLEAR: game_reset_d = 1'b1;
            READY:       game_display_d = 1'b1;
            PLAY, PAUSE: begin
                game_display_d = 1'b1;
                snake_start_d  = 1'b1;
            end
            OVER: begin
                game_display_d = 1'b1;
                snake_start_d  = 1'b1;
                game_over_d    = 1'b1;
            end
            default: game_reset_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            clear_cnt <= '0;
        else if (state == CLEAR)
            clear_cnt <= clear_cnt + CW'(1);
        else
            clear_cnt <= '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending   <= DIR_RIGHT;
            dir_out   <= DIR_RIGHT;
            move_tick <= 1'b0;
        end else begin
            move_tick <= tick;
            if (state == CLEAR) begin
                pending <= DIR_RIGHT;
                dir_out <= DIR_RIGHT;
            end else begin
                if (dir_accept)
                    pending <= dir_req;
                if ((state == READY) && dir_accept)
                    dir_out <= dir_req;
                else if (tick)
                    dir_out <= pending;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            eaten <= 8'd0;
        else if (state == CLEAR)
            eaten <= 8'd0;
        else if (food && (eaten != 8'hFF))
            eaten <= eaten + 8'd1;
    end

`ifdef SNAKE_CTRL_SPEEDUP_EN
    localparam int SW        = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
    localparam int LEVEL_MAX = ((BASE_FRAMES - MIN_FRAMES) > 15) ? 15 : (BASE_FRAMES - MIN_FRAMES);

    logic [SW-1:0] speed_cnt;

    // speed_cnt tracks eaten mod SPEEDUP_EVERY without a divider
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            speed_cnt <= '0;
            level     <= 4'd0;
        end else if (state == CLEAR) begin
            speed_cnt <= '0;
            level     <= 4'd0;
        end else if (food && (eaten != 8'hFF)) begin
            if (speed_cnt == SW'(SPEEDUP_EVERY - 1)) begin
                speed_cnt <= '0;
                if (level < 4'(LEVEL_MAX))
                    level <= level + 4'd1;
            end else begin
                speed_cnt <= speed_cnt + SW'(1);
            end
        end
    end
`else
    assign level = 4'd0;
`endif

    snake_tick_gen #(
        .FRAME_DIV   (FRAME_DIV),
        .BASE_FRAMES (BASE_FRAMES),
        .MIN_FRAMES  (MIN_FRAMES)
    ) u_tick_gen (
        .clk       (clk),
        .resetn    (resetn),
        .run       (state == PLAY),
        .clear     (state == CLEAR),
        .level     (level),
        .move_tick (tick)
    );

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed scoreboard bench for snake_game_ctrl with small timing parameters.
// Expected level/period follow SNAKE_CTRL_SPEEDUP_EN when the bench is built with it.
module tb_snake_game_ctrl;
    import snake_pkg::*;

    localparam int FRAME_DIV     = 4;
    localparam int BASE_FRAMES   = 3;
    localparam int MIN_FRAMES    = 1;
    localparam int SPEEDUP_EVERY = 2;
    localparam int CLEAR_CYCLES  = 8;
    localparam int BASE_PERIOD   = FRAME_DIV * BASE_FRAMES;
`ifdef SNAKE_CTRL_SPEEDUP_EN
    localparam int EXP_LEVEL     = 2;
    localparam int FAST_PERIOD   = FRAME_DIV * 1;
`else
    localparam int EXP_LEVEL     = 0;
    localparam int FAST_PERIOD   = BASE_PERIOD;
`endif

    logic       clk, resetn, start_btn, pause_btn, good_collision, bad_collision;
    logic [3:0] dir_req;
    logic       game_reset, game_display, snake_start, move_tick, game_over;
    logic [3:0] dir_out, level;
    logic [7:0] eaten;
    logic [2:0] state_out;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    snake_game_ctrl #(
        .FRAME_DIV     (FRAME_DIV),
        .BASE_FRAMES   (BASE_FRAMES),
        .MIN_FRAMES    (MIN_FRAMES),
        .SPEEDUP_EVERY (SPEEDUP_EVERY),
        .CLEAR_CYCLES  (CLEAR_CYCLES)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_btn      (start_btn),
        .pause_btn      (pause_btn),
        .dir_req        (dir_req),
        .good_collision (good_collision),
        .bad_collision  (bad_collision),
        .game_reset     (game_reset),
        .game_display   (game_display),
        .snake_start    (snake_start),
        .move_tick      (move_tick),
        .dir_out        (dir_out),
        .level          (level),
        .eaten          (eaten),
        .game_over      (game_over),
        .state_out      (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
        end else begin
            e = exp_q.pop_front();
            assert (observed === e.value) else begin
                failures++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.value);
            end
        end
    endtask

    // Drives one cycle of inputs starting at a negedge, then returns them to idle
    task automatic apply_stimulus(input logic [3:0] dir, input logic st, input logic pa,
                                  input logic gc, input logic bc);
        dir_req        = dir;
        start_btn      = st;
        pause_btn      = pa;
        good_collision = gc;
        bad_collision  = bc;
        @(negedge clk);
        dir_req        = 4'b0000;
        start_btn      = 1'b0;
        pause_btn      = 1'b0;
        good_collision = 1'b0;
        bad_collision  = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (move_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_val(tag, 32'd1);
        check_output(32'(move_tick));
    endtask

    task automatic measure_period(input string tag, input int exp_period);
        int w = 0;
        int l = 0;
        wait_tick({tag, "_first"});
        while (move_tick === 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (move_tick !== 1'b1 && l < 200) begin
            @(negedge clk);
            l++;
        end
        expect_val({tag, "_width"}, 32'd1);
        check_output(32'(w));
        expect_val({tag, "_period"}, 32'(exp_period));
        check_output(32'(w + l));
    endtask

    initial begin
        int n;
        int ticks;
        logic gr_ok;

        resetn = 1'b0;
        start_btn = 1'b0; pause_btn = 1'b0; good_collision = 1'b0; bad_collision = 1'b0;
        dir_req = 4'b0000;
        tick_n(2);

        expect_val("rst_state", 32'd0);        check_output(32'(state_out));
        expect_val("rst_game_reset", 32'd1);   check_output(32'(game_reset));
        expect_val("rst_display", 32'd0);      check_output(32'(game_display));
        expect_val("rst_snake_start", 32'd0);  check_output(32'(snake_start));
        expect_val("rst_move_tick", 32'd0);    check_output(32'(move_tick));
        expect_val("rst_dir_out", 32'h8);      check_output(32'(dir_out));
        expect_val("rst_level", 32'd0);        check_output(32'(level));
        expect_val("rst_eaten", 32'd0);        check_output(32'(eaten));
        expect_val("rst_game_over", 32'd0);    check_output(32'(game_over));

        resetn = 1'b1;
        tick_n(3);
        expect_val("idle_hold", 32'd0);
        check_output(32'(state_out));

        // Start: CLEAR for exactly CLEAR_CYCLES with game_reset held, then READY
        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        gr_ok = 1'b1;
        while (state_out == 3'd1 && n < 50) begin
            if (game_reset !== 1'b1) gr_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        expect_val("clear_len", 32'(CLEAR_CYCLES));  check_output(32'(n));
        expect_val("clear_game_reset", 32'd1);      check_output(32'(gr_ok));
        expect_val("ready_state", 32'd2);           check_output(32'(state_out));
        expect_val("ready_display", 32'd1);         check_output(32'(game_display));
        expect_val("ready_snake_start", 32'd0);     check_output(32'(snake_start));
        expect_val("ready_game_reset", 32'd0);      check_output(32'(game_reset));

        apply_stimulus(DIR_UP, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val("play_state", 32'd3);            check_output(32'(state_out));
        expect_val("play_dir_up", 32'(DIR_UP));     check_output(32'(dir_out));
        expect_val("play_snake_start", 32'd1);      check_output(32'(snake_start));
        measure_period("base", BASE_PERIOD);

        // Directions: turn right, then up followed by a blocked left, then left against right
        apply_stimulus(DIR_RIGHT, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_right");
        expect_val("dir_right", 32'(DIR_RIGHT));    check_output(32'(dir_out));
        apply_stimulus(DIR_UP, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(DIR_LEFT, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_double_turn");
        expect_val("dir_double_turn", 32'(DIR_UP)); check_output(32'(dir_out));
        apply_stimulus(DIR_RIGHT, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_right2");
        apply_stimulus(DIR_LEFT, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_reverse");
        expect_val("dir_reverse_rej", 32'(DIR_RIGHT)); check_output(32'(dir_out));
        apply_stimulus(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick("tick_invalid");
        expect_val("dir_invalid_rej", 32'(DIR_RIGHT)); check_output(32'(dir_out));

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
            tick_n(1);
        end
        expect_val("food_eaten", 32'd4);            check_output(32'(eaten));
        expect_val("food_level", 32'(EXP_LEVEL));   check_output(32'(level));
        measure_period("fast", FAST_PERIOD);

        // Pause two cycles into a move, hold, then resume for the remaining count
        tick_n(1);
        apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_val("pause_state", 32'd4);           check_output(32'(state_out));
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (move_tick === 1'b1) ticks++;
        end
        expect_val("pause_no_tick", 32'd0);         check_output(32'(ticks));
        pause_btn = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            pause_btn = 1'b0;
            n++;
        end while (move_tick !== 1'b1 && n < 200);
        expect_val("resume_remaining", 32'(FAST_PERIOD - 1));
        check_output(32'(n));

        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_val("play_ignores_start", 32'd3);    check_output(32'(state_out));

        apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_val("over_state", 32'd5);            check_output(32'(state_out));
        expect_val("over_flag", 32'd1);             check_output(32'(game_over));
        expect_val("over_eaten_kept", 32'd4);       check_output(32'(eaten));
        apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (move_tick === 1'b1) ticks++;
        end
        expect_val("over_no_tick", 32'd0);          check_output(32'(ticks));
        expect_val("over_ignores_food", 32'd4);     check_output(32'(eaten));

        apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_val("restart_clear", 32'd1);         check_output(32'(state_out));
        n = 0;
        while (state_out != 3'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        expect_val("restart_ready", 32'd2);         check_output(32'(state_out));
        expect_val("restart_eaten", 32'd0);         check_output(32'(eaten));
        expect_val("restart_level", 32'd0);         check_output(32'(level));
        expect_val("restart_dir", 32'(DIR_RIGHT));  check_output(32'(dir_out));

        apply_stimulus(DIR_DOWN, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val("replay_dir_down", 32'(DIR_DOWN)); check_output(32'(dir_out));
        tick_n(5);
        #2 resetn = 1'b0;
        #1;
        expect_val("async_state", 32'd0);           check_output(32'(state_out));
        expect_val("async_game_reset", 32'd1);      check_output(32'(game_reset));
        expect_val("async_display", 32'd0);         check_output(32'(game_display));
        expect_val("async_snake_start", 32'd0);     check_output(32'(snake_start));
        expect_val("async_dir_out", 32'h8);         check_output(32'(dir_out));
        @(negedge clk);
        resetn = 1'b1;
        tick_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
